branch_resolution_unit: RTL and testbench
=========================================

# branch_resolution_unit

Execute-side counterpart of the fetch-stage branch predictor. Holds each fetched instruction's prediction in an in-order queue until the instruction reaches EX, and compares that prediction against the resolved outcome. It raises a same-cycle front-end redirect on mismatch and sends a registered update beat back to the predictor's training port. It also keeps branch and misprediction counters.

## Interface
- `DEPTH`, 4, in-flight prediction entries; power of 2, ≥2
- `PTR_BITS`, 2, log2(`DEPTH`)
- `CNT_WIDTH`, 32, width of performance counters
- `clk` in 1: the only clock
- `rst` in 1: synchronous, active-high reset
- `fetch_valid` in 1: an instruction leaves IF with its prediction
- `program_counter_fetch` in 32: PC of that instruction
- `prediction_taken` in 1: predicted taken
- `prediction_target` in 32: predicted target
- `fetch_ready` out 1: queue can accept a push (not full)
- `execute_valid` in 1: an instruction is in EX this cycle (pops one entry)
- `program_counter_execute` in 32: PC of the instruction in EX
- `is_branch_execute`, `is_jump_execute` in 1 each: instruction class
- `branch_taken_execute` in 1: actual outcome
- `branch_target_execute` in 32: actual target
- `flush_external` in 1: trap/exception flush, empties the queue
- `redirect_valid` out 1: mispredict; fetch must restart
- `redirect_pc` out 32: restart address
- `update_valid` out 1: training beat, branch or jump only
- `update_pc`, `update_target` out 32; `update_taken`, `update_is_branch`, `update_is_jump` out 1
- `branch_count`, `mispredict_count` out `CNT_WIDTH`
- `protocol_error` out 1: sticky; pop attempted while empty

## Operation
- Queue is a circular FIFO with rd/wr pointers of `PTR_BITS`+1 bits.
  - Full when the MSBs differ and the low bits are equal.
  - Empty when the pointers are equal.
- Push: `fetch_valid && fetch_ready && !redirect_valid && !flush_external` writes {pc, taken, target} at wr_ptr.
- `fetch_ready` = !full. A push while full is dropped, even if a pop occurs in the same cycle.
- Pop: `execute_valid && !empty` reads the head entry.
- `execute_valid && empty`: sets `protocol_error`. No pop, redirect or update.
- Actual next PC: `branch_taken_execute ? branch_target_execute : program_counter_execute + 4`. The add is 32-bit and wraps.
- Mispredict is any of:
  - head.taken ≠ actual taken;
  - both taken and head.target ≠ `branch_target_execute`;
  - instruction is neither branch nor jump and head.taken = 1.
- On mispredict: `redirect_valid`=1 and `redirect_pc`=actual next PC. Next cycle, both pointers reset to 0 and all younger entries are discarded.
- `flush_external`: pointers reset next cycle. This has priority over push, pop and counter updates. No redirect is generated.
- `update_valid` is registered. It is asserted one cycle after a pop of a branch/jump and carries the EX inputs captured at that pop. Non-branch mispredicts produce no update.
- `branch_count` increments on each branch/jump pop. `mispredict_count` increments on each mispredict. Both wrap.
- EX PC ≠ head.pc is not checked; the queue is strictly in-order.

## Timing
- Reset values:
  - Outputs: all 0, except `fetch_ready`=1.
  - State: pointers 0, counters 0, `protocol_error` 0.
- `redirect_valid`/`redirect_pc`: combinational from EX inputs and the queue head, 0-cycle latency. Low whenever `rst`.
- Update beat: exactly 1 cycle after the pop, single-cycle pulse.
- Push and pop in the same cycle on a non-full, non-empty queue: occupancy unchanged.
- Push to an empty queue is poppable from the next cycle onward.
- Reset mid-operation discards all entries and any pending update beat.

## Structure
- Shared package constants: `INSTR_BYTES`=4 and `PRED_ENTRY_W`=65 (pc, taken, target packing).
- One natural sub-module: `pred_fifo`, a parameterised synchronous FIFO with a clear input. Compare, redirect and counter logic stay in the top module.

## Test plan
- Push pc=0x100 (taken=1, tgt=0x200); EX branch taken, tgt 0x200 → no redirect; next cycle update_valid=1, update_taken=1; branch_count=1.
- Push pc=0x104 (taken=0); EX branch taken, tgt 0x300 → redirect_valid=1, redirect_pc=0x300 same cycle; queue empty next cycle; mispredict_count=1.
- Push pc=0x108 (taken=1, tgt=0x400); EX non-branch → redirect_pc=0x10C; update_valid stays 0.
- Push 4 entries with no pop → fetch_ready=0; a 5th push with a simultaneous pop is dropped; occupancy=3 next cycle.
- execute_valid on an empty queue → protocol_error=1 and stays 1 until rst.
- Queue holding 3 entries, flush_external=1 with a push the same cycle → queue empty, no redirect, counters unchanged; rst asserted mid-stream → all outputs at reset values next cycle.

Source files
------------

// File: rtl/branch_resolution_unit_pkg.sv
// ============================================================================
//  branch_resolution_unit_pkg
//  Shared constants, prediction entry layout and sequential-PC helper.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package branch_resolution_unit_pkg;

   localparam int INSTR_BYTES  = 4;
   localparam int PRED_ENTRY_W = 65;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } pred_entry_t;

   function automatic logic [31:0] seq_next_pc(input logic [31:0] pc);
      return pc + 32'(INSTR_BYTES);
   endfunction

endpackage

`default_nettype wire

// File: rtl/branch_resolution_unit_pred_fifo.sv
// ============================================================================
//  pred_fifo
//  Synchronous circular FIFO with wrap-bit pointers and a one-cycle clear.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module pred_fifo
   import branch_resolution_unit_pkg::*;
#(
   parameter int WIDTH    = PRED_ENTRY_W,
   parameter int DEPTH    = 4,
   parameter int PTR_BITS = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [PTR_BITS:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_BITS:0] rd_ptr_q, rd_ptr_d;
   logic              w_push;
   logic              w_pop;

   assign full_o  = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
                    (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign head_o  = mem_q[rd_ptr_q[PTR_BITS-1:0]];

   // A push into a full queue is dropped even if a pop frees a slot this cycle.
   assign w_push = push_i && !full_o;
   assign w_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (w_push) wr_ptr_d = wr_ptr_q + (PTR_BITS+1)'(1);
         if (w_pop)  rd_ptr_d = rd_ptr_q + (PTR_BITS+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !clear_i) mem_q[wr_ptr_q[PTR_BITS-1:0]] <= push_data_i;
   end

endmodule

`default_nettype wire

// File: rtl/branch_resolution_unit.sv
// ============================================================================
//  branch_resolution_unit
//  Checks queued fetch predictions against EX outcomes; redirects and trains.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module branch_resolution_unit
   import branch_resolution_unit_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int PTR_BITS  = 2,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fetch_valid,
   input  logic [31:0]          program_counter_fetch,
   input  logic                 prediction_taken,
   input  logic [31:0]          prediction_target,
   output logic                 fetch_ready,
   input  logic                 execute_valid,
   input  logic [31:0]          program_counter_execute,
   input  logic                 is_branch_execute,
   input  logic                 is_jump_execute,
   input  logic                 branch_taken_execute,
   input  logic [31:0]          branch_target_execute,
   input  logic                 flush_external,
   output logic                 redirect_valid,
   output logic [31:0]          redirect_pc,
   output logic                 update_valid,
   output logic [31:0]          update_pc,
   output logic [31:0]          update_target,
   output logic                 update_taken,
   output logic                 update_is_branch,
   output logic                 update_is_jump,
   output logic [CNT_WIDTH-1:0] branch_count,
   output logic [CNT_WIDTH-1:0] mispredict_count,
   output logic                 protocol_error
);

   pred_entry_t w_head;
   pred_entry_t w_push_entry;
   logic        w_full;
   logic        w_empty;
   logic        w_pop;
   logic        w_push;
   logic        w_ctrl;
   logic        w_mispredict;
   logic [31:0] w_actual_pc;
   logic        w_unused_head_pc;

   logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
   logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;
   logic                 protocol_error_q, protocol_error_d;
   logic                 update_valid_q;
   logic [31:0]          update_pc_q, update_target_q;
   logic                 update_taken_q, update_is_branch_q, update_is_jump_q;

   // The queue is strictly in-order, so the stored PC is never compared.
   assign w_unused_head_pc = ^w_head.pc;

   assign w_push_entry = '{pc: program_counter_fetch, taken: prediction_taken,
                           target: prediction_target};

   assign w_ctrl      = is_branch_execute || is_jump_execute;
   assign w_pop       = execute_valid && !w_empty && !flush_external && !rst;
   assign w_actual_pc = branch_taken_execute ? branch_target_execute
                                             : seq_next_pc(program_counter_execute);

   assign w_mispredict = w_pop &&
      ((w_head.taken != branch_taken_execute) ||
       (w_head.taken && branch_taken_execute && (w_head.target != branch_target_execute)) ||
       (!w_ctrl && w_head.taken));

   assign w_push = fetch_valid && !w_full && !w_mispredict && !flush_external;

   pred_fifo #(
      .WIDTH    (PRED_ENTRY_W),
      .DEPTH    (DEPTH),
      .PTR_BITS (PTR_BITS)
   ) u_pred_fifo (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (flush_external || w_mispredict),
      .push_i      (w_push),
      .push_data_i (w_push_entry),
      .pop_i       (w_pop),
      .full_o      (w_full),
      .empty_o     (w_empty),
      .head_o      (w_head)
   );

   always_comb begin
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      protocol_error_d   = protocol_error_q;
      if (w_pop && w_ctrl) branch_count_d     = branch_count_q + CNT_WIDTH'(1);
      if (w_mispredict)    mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
      if (execute_valid && w_empty && !flush_external) protocol_error_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
         protocol_error_q   <= 1'b0;
         update_valid_q     <= 1'b0;
         update_pc_q        <= '0;
         update_target_q    <= '0;
         update_taken_q     <= 1'b0;
         update_is_branch_q <= 1'b0;
         update_is_jump_q   <= 1'b0;
      end else begin
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
         protocol_error_q   <= protocol_error_d;
         update_valid_q     <= w_pop && w_ctrl;
         if (w_pop && w_ctrl) begin
            update_pc_q        <= program_counter_execute;
            update_target_q    <= branch_target_execute;
            update_taken_q     <= branch_taken_execute;
            update_is_branch_q <= is_branch_execute;
            update_is_jump_q   <= is_jump_execute;
         end
      end
   end

   assign fetch_ready      = !w_full;
   assign redirect_valid   = w_mispredict;
   assign redirect_pc      = w_mispredict ? w_actual_pc : 32'h0;
   assign update_valid     = update_valid_q;
   assign update_pc        = update_pc_q;
   assign update_target    = update_target_q;
   assign update_taken     = update_taken_q;
   assign update_is_branch = update_is_branch_q;
   assign update_is_jump   = update_is_jump_q;
   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;
   assign protocol_error   = protocol_error_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolution_unit.sv
// ============================================================================
//  tb_branch_resolution_unit
//  Scoreboarded directed + random bench against a queue-based reference model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolution_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_valid = 0, prediction_taken = 0;
   logic [31:0] program_counter_fetch = 0, prediction_target = 0;
   logic        execute_valid = 0, is_branch_execute = 0, is_jump_execute = 0;
   logic        branch_taken_execute = 0, flush_external = 0;
   logic [31:0] program_counter_execute = 0, branch_target_execute = 0;
   logic        fetch_ready, redirect_valid, update_valid, update_taken;
   logic        update_is_branch, update_is_jump, protocol_error;
   logic [31:0] redirect_pc, update_pc, update_target, branch_count, mispredict_count;

   always #5 clk = ~clk;

   branch_resolution_unit #(.DEPTH(DEPTH), .PTR_BITS(2), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .fetch_valid(fetch_valid), .program_counter_fetch(program_counter_fetch),
      .prediction_taken(prediction_taken), .prediction_target(prediction_target),
      .fetch_ready(fetch_ready),
      .execute_valid(execute_valid), .program_counter_execute(program_counter_execute),
      .is_branch_execute(is_branch_execute), .is_jump_execute(is_jump_execute),
      .branch_taken_execute(branch_taken_execute), .branch_target_execute(branch_target_execute),
      .flush_external(flush_external),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .update_valid(update_valid), .update_pc(update_pc), .update_target(update_target),
      .update_taken(update_taken), .update_is_branch(update_is_branch),
      .update_is_jump(update_is_jump),
      .branch_count(branch_count), .mispredict_count(mispredict_count),
      .protocol_error(protocol_error)
   );

   typedef struct {
      logic [31:0] pc;
      bit          taken;
      logic [31:0] tgt;
   } ent_t;

   typedef struct {
      bit          rv;
      logic [31:0] rpc;
      bit          fr;
      logic [31:0] bc, mc;
      bit          pe;
      bit          uv;
      logic [31:0] upc, utgt;
      bit          ut, ub, uj;
   } exp_t;

   // Reference model state
   ent_t        mq[$];
   logic [31:0] m_bc = 0, m_mc = 0;
   bit          m_pe = 0;
   bit          m_uv = 0, m_ut = 0, m_ub = 0, m_uj = 0;
   logic [31:0] m_upc = 0, m_utgt = 0;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, expv);
      end
   endtask

   // Monitor: compares what the DUT presents mid-cycle against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("redirect_valid", 32'(redirect_valid), 32'(e.rv));
            if (redirect_valid && e.rv) check("redirect_pc", redirect_pc, e.rpc);
            check("fetch_ready", 32'(fetch_ready), 32'(e.fr));
            check("branch_count", branch_count, e.bc);
            check("mispredict_count", mispredict_count, e.mc);
            check("protocol_error", 32'(protocol_error), 32'(e.pe));
            check("update_valid", 32'(update_valid), 32'(e.uv));
            if (update_valid && e.uv) begin
               check("update_pc", update_pc, e.upc);
               check("update_target", update_target, e.utgt);
               check("update_flags", {29'h0, update_taken, update_is_branch, update_is_jump},
                     {29'h0, e.ut, e.ub, e.uj});
            end
         end
      end
   end

   // Drive one cycle of inputs, push the expected outputs, then advance the model.
   task automatic step(input bit fv, input logic [31:0] pcf, input bit pt, input logic [31:0] ptg,
                       input bit ev, input logic [31:0] pce, input bit ib, input bit ij,
                       input bit tk, input logic [31:0] tg, input bit fl, input bit r);
      exp_t e;
      bit   pop, mis, ctrl;
      ent_t h;
      @(posedge clk);
      #1;
      fetch_valid = fv; program_counter_fetch = pcf;
      prediction_taken = pt; prediction_target = ptg;
      execute_valid = ev; program_counter_execute = pce;
      is_branch_execute = ib; is_jump_execute = ij;
      branch_taken_execute = tk; branch_target_execute = tg;
      flush_external = fl; rst = r;

      ctrl = ib || ij;
      pop  = !r && !fl && ev && (mq.size() > 0);
      mis  = 0;
      if (pop) begin
         h   = mq[0];
         mis = (h.taken != tk) || (h.taken && tk && h.tgt != tg) || (!ctrl && h.taken);
      end
      e.rv  = mis;
      e.rpc = tk ? tg : pce + 32'd4;
      e.fr  = (mq.size() < DEPTH);
      e.bc  = m_bc; e.mc = m_mc; e.pe = m_pe;
      e.uv  = m_uv; e.upc = m_upc; e.utgt = m_utgt;
      e.ut  = m_ut; e.ub = m_ub; e.uj = m_uj;
      sb.push_back(e);

      if (r) begin
         mq.delete();
         m_bc = 0; m_mc = 0; m_pe = 0; m_uv = 0;
      end else if (fl) begin
         mq.delete();
         m_uv = 0;
      end else begin
         bit push_ok;
         push_ok = fv && (mq.size() < DEPTH) && !mis;
         if (ev && mq.size() == 0) m_pe = 1;
         m_uv = pop && ctrl;
         if (pop) begin
            void'(mq.pop_front());
            if (ctrl) begin
               m_bc = m_bc + 1;
               m_upc = pce; m_utgt = tg; m_ut = tk; m_ub = ib; m_uj = ij;
            end
            if (mis) begin
               m_mc = m_mc + 1;
               mq.delete();
            end
         end
         if (push_ok) mq.push_back('{pc: pcf, taken: pt, tgt: ptg});
      end
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic push(input logic [31:0] pc, input bit t, input logic [31:0] tg);
      step(1, pc, t, tg, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [31:0] tset [2];
      tset[0] = 32'h200; tset[1] = 32'h300;

      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle();

      // Correctly predicted taken branch, then training beat
      push(32'h100, 1, 32'h200);
      step(0, 0, 0, 0, 1, 32'h100, 1, 0, 1, 32'h200, 0, 0);
      idle();
      // Predicted not-taken, actually taken
      push(32'h104, 0, 0);
      step(0, 0, 0, 0, 1, 32'h104, 1, 0, 1, 32'h300, 0, 0);
      idle();
      // Non-branch predicted taken
      push(32'h108, 1, 32'h400);
      step(0, 0, 0, 0, 1, 32'h108, 0, 0, 0, 0, 0, 0);
      idle(); idle();

      // Fill, drop a push that coincides with a pop, refill to full
      for (int i = 0; i < 4; i++) push(32'h500 + 32'(i) * 4, 0, 0);
      idle();
      step(1, 32'h600, 0, 0, 1, 32'h500, 1, 0, 0, 32'h700, 0, 0);
      idle();
      push(32'h604, 0, 0);
      idle();
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 32'h504 + 32'(i) * 4, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 32'h800, 1, 0, 1, 32'h900, 0, 0);
      idle(); idle();

      // Flush with a simultaneous push, then reset mid-stream
      for (int i = 0; i < 3; i++) push(32'hA00 + 32'(i) * 4, 1, 32'h200);
      step(1, 32'hB00, 1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 0);
      idle();
      push(32'hC00, 1, 32'h200);
      step(0, 0, 0, 0, 1, 32'hC00, 0, 1, 1, 32'h200, 0, 0);
      step(1, 32'hC04, 0, 0, 1, 32'hC04, 1, 0, 1, 32'h300, 0, 1);
      idle(); idle();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         bit ib, ij, tk, ctrl;
         ib   = ($urandom_range(0, 1) == 1);
         ij   = !ib && ($urandom_range(0, 3) == 0);
         ctrl = ib || ij;
         tk   = ctrl ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
         step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
              tset[$urandom_range(0, 1)],
              $urandom_range(0, 1) == 1, $urandom, ib, ij, tk, tset[$urandom_range(0, 1)],
              $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
      end

      idle();
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
